// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundle between the stall controller and the CPU pipeline / I/O device.
//
//   stallreq_id  ID-stage load-use stall request
//   stallreq_ex  EX-stage multi-cycle stall request
//   ex_in/ex_out EX holds an IN / OUT instruction
//   io_ack       device acknowledge (level)
//   stall[5:0]   stall vector, bit0 PC .. bit5 WB, 1 = stop
//   io_req       device request
//   io_dir       transfer direction, 1 = OUT
//   io_done      one-cycle completion pulse to EX
//   io_timeout   sticky device timeout flag
//   stall_cnt    saturating count of PC-stall cycles
//
// The master modport is the controller side; slave is the pipeline/device side.
// CNT_W must match the CNT_W of the pipe_ctrl instance it is bound to.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             stallreq_id;
  logic             stallreq_ex;
  logic             ex_in;
  logic             ex_out;
  logic             io_ack;
  logic [5:0]       stall;
  logic             io_req;
  logic             io_dir;
  logic             io_done;
  logic             io_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    input  stallreq_id, stallreq_ex, ex_in, ex_out, io_ack,
    output stall, io_req, io_dir, io_done, io_timeout, stall_cnt
  );

  modport slave (
    output stallreq_id, stallreq_ex, ex_in, ex_out, io_ack,
    input  stall, io_req, io_dir, io_done, io_timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall controller of the 5-stage CPU.
//
// Merges the ID load-use and EX multi-cycle stall requests into the 6-bit stall
// vector, runs the IN/OUT device handshake (IDLE -> REQ -> DONE) and counts
// cycles in which the PC is stalled.
//
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous reset, active low
//   bus  pipe_ctrl_if.master (stall requests, I/O handshake, stall vector, counter)
//
// Optional feature, macro PIPE_CTRL_IO_TIMEOUT_EN: when defined, a REQ that sees
// no io_ack for IO_TIMEOUT_CYCLES cycles is force-completed and io_timeout is set
// (sticky until reset). When undefined, REQ waits for io_ack indefinitely and
// io_timeout is tied low.
module pipe_ctrl #(
  parameter int CNT_W             = 32,
  parameter int IO_TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic             io_req_q;
  logic             io_dir_q;
  logic             io_done_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             io_pend;
  logic             stall_io;
  logic             to_hit;
  logic [5:0]       stall_v;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  assign io_pend = bus.ex_in | bus.ex_out;

  // DONE deliberately does not stall on I/O so EX/MEM captures the instruction
  // in the same cycle io_done is presented to EX.
  always_comb begin
    stall_io = ((state == IDLE) && io_pend) || (state == REQ);
    if (!rst)
      stall_v = 6'b000000;
    else if (stall_io || bus.stallreq_ex)
      stall_v = 6'b001111;
    else if (bus.stallreq_id)
      stall_v = 6'b000111;
    else
      stall_v = 6'b000000;
  end

`ifdef PIPE_CTRL_IO_TIMEOUT_EN
  localparam int              TO_W    = $clog2(IO_TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(IO_TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;
  logic            io_timeout_q;

  // to_cnt counts completed ack-less REQ cycles; the cycle that would make it
  // reach IO_TIMEOUT_CYCLES forces completion instead.
  assign to_hit = (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt       <= '0;
      io_timeout_q <= 1'b0;
    end else if ((state == IDLE) && io_pend) begin
      to_cnt <= '0;
    end else if ((state == REQ) && !bus.io_ack) begin
      if (to_hit)
        io_timeout_q <= 1'b1;
      else
        to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign bus.io_timeout = io_timeout_q;
`else
  localparam int unused_to_cycles = IO_TIMEOUT_CYCLES;

  assign to_hit         = 1'b0;
  assign bus.io_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      io_req_q  <= 1'b0;
      io_dir_q  <= 1'b0;
      io_done_q <= 1'b0;
    end else begin
      io_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (io_pend) begin
            state    <= REQ;
            io_req_q <= 1'b1;
            io_dir_q <= bus.ex_out;  // OUT wins if both are flagged
          end
        end
        REQ: begin
          // ack is checked first so it beats a coincident timeout
          if (bus.io_ack || to_hit) begin
            state     <= DONE;
            io_req_q  <= 1'b0;
            io_done_q <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      stall_cnt_q <= '0;
    else if (stall_v[0])
      stall_cnt_q <= sat_inc(stall_cnt_q);
  end

  assign bus.stall     = stall_v;
  assign bus.io_req    = io_req_q;
  assign bus.io_dir    = io_dir_q;
  assign bus.io_done   = io_done_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed bench for pipe_ctrl. A 3-bit stall counter is used so
// saturation is reachable; IO_TIMEOUT_CYCLES = 4 for the optional timeout build.
// Observed word per cycle: {stall[5:0], io_req, io_dir, io_done, io_timeout, stall_cnt[2:0]}.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  pipe_ctrl_if #(.CNT_W(3)) bus ();

  pipe_ctrl #(.CNT_W(3), .IO_TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [12:0] obs();
    return {bus.stall, bus.io_req, bus.io_dir, bus.io_done, bus.io_timeout, bus.stall_cnt};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic id, input logic ex, input logic i, input logic o,
                            input logic a);
    bus.stallreq_id = id;
    bus.stallreq_ex = ex;
    bus.ex_in       = i;
    bus.ex_out      = o;
    bus.io_ack      = a;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_inputs(0, 0, 0, 0, 0);
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    rst = 1'b0;
    set_inputs(1, 1, 1, 1, 1);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      got = obs();
      vectors++;
      if (got !== 13'b0) begin
        miscompares++;
        $display("FAIL reset_hold cyc%0d: got %b expected %b", k, got, 13'b0);
      end
      next_cycle();
    end
    rst = 1'b1;
    set_inputs(0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      got = obs();
      vectors++;
      if (got !== 13'b0) begin
        miscompares++;
        $display("FAIL reset_idle cyc%0d: got %b expected %b", k, got, 13'b0);
      end
      next_cycle();
    end
  endtask

  task automatic test_load_use();
    logic [12:0] exp_t [2];
    logic [12:0] got;
    exp_t = '{{6'b000111, 4'b0000, 3'd0}, {6'b000000, 4'b0000, 3'd1}};
    do_reset();
    for (int k = 0; k < 2; k++) begin
      set_inputs(k == 0, 0, 0, 0, 0);
      @(negedge clk);
      got = obs();
      vectors++;
      if (got !== exp_t[k]) begin
        miscompares++;
        $display("FAIL load_use cyc%0d: got %b expected %b", k, got, exp_t[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_out_ack_delay();
    logic [12:0] exp_t [7];
    logic [12:0] got;
    exp_t = '{{6'b001111, 4'b0000, 3'd0},
              {6'b001111, 4'b1100, 3'd1},
              {6'b001111, 4'b1100, 3'd2},
              {6'b001111, 4'b1100, 3'd3},
              {6'b001111, 4'b1100, 3'd4},
              {6'b000000, 4'b0110, 3'd5},
              {6'b000000, 4'b0100, 3'd5}};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      set_inputs(0, 0, 0, k <= 5, (k >= 4) && (k <= 5));
      @(negedge clk);
      got = obs();
      vectors++;
      if (got !== exp_t[k]) begin
        miscompares++;
        $display("FAIL out_ack_delay cyc%0d: got %b expected %b", k, got, exp_t[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp_t [8];
    logic [12:0] got;
    int          pulses;
    exp_t = '{{6'b001111, 4'b0000, 3'd0},
              {6'b001111, 4'b1000, 3'd1},
              {6'b000000, 4'b0010, 3'd2},
              {6'b001111, 4'b0000, 3'd2},
              {6'b001111, 4'b1000, 3'd3},
              {6'b000000, 4'b0010, 3'd4},
              {6'b000000, 4'b0000, 3'd4},
              {6'b000000, 4'b0000, 3'd4}};
    pulses = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      set_inputs(0, 0, k <= 5, 0, 1);
      @(negedge clk);
      got = obs();
      if (bus.io_done === 1'b1) pulses++;
      vectors++;
      if (got !== exp_t[k]) begin
        miscompares++;
        $display("FAIL back_to_back cyc%0d: got %b expected %b", k, got, exp_t[k]);
      end
      next_cycle();
    end
    vectors++;
    if (pulses !== 2) begin
      miscompares++;
      $display("FAIL back_to_back_pulses: got %0d io_done pulses expected 2", pulses);
    end
  endtask

  task automatic test_direction();
    logic [12:0] exp_t [8];
    logic [12:0] got;
    exp_t = '{{6'b001111, 4'b0000, 3'd0},
              {6'b001111, 4'b1100, 3'd1},
              {6'b000000, 4'b0110, 3'd2},
              {6'b000000, 4'b0100, 3'd2},
              {6'b001111, 4'b0100, 3'd2},
              {6'b001111, 4'b1000, 3'd3},
              {6'b000000, 4'b0010, 3'd4},
              {6'b000000, 4'b0000, 3'd4}};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      set_inputs(0, 0, (k <= 2) || ((k >= 4) && (k <= 6)), k <= 2, 1);
      @(negedge clk);
      got = obs();
      vectors++;
      if (got !== exp_t[k]) begin
        miscompares++;
        $display("FAIL direction cyc%0d: got %b expected %b", k, got, exp_t[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_combined_and_mid_reset();
    logic [12:0] exp_t [8];
    logic [12:0] got;
    exp_t = '{{6'b001111, 4'b0000, 3'd0},
              {6'b001111, 4'b0000, 3'd1},
              {6'b001111, 4'b0000, 3'd2},
              {6'b001111, 4'b1000, 3'd3},
              {6'b000000, 4'b1000, 3'd4},
              {6'b000000, 4'b0000, 3'd0},
              {6'b000000, 4'b0000, 3'd0},
              {6'b000000, 4'b0000, 3'd0}};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      case (k)
        0:       set_inputs(1, 1, 0, 0, 0);
        1:       set_inputs(0, 1, 0, 0, 0);
        2, 3, 4: set_inputs(1, 0, 1, 0, 0);
        default: set_inputs(0, 0, 0, 0, 1);
      endcase
      rst = (k == 4) ? 1'b0 : 1'b1;
      @(negedge clk);
      got = obs();
      vectors++;
      if (got !== exp_t[k]) begin
        miscompares++;
        $display("FAIL combined_mid_reset cyc%0d: got %b expected %b", k, got, exp_t[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_saturate();
    logic [12:0] exp_v;
    logic [12:0] got;
    do_reset();
    for (int k = 0; k < 11; k++) begin
      set_inputs(k <= 9, 0, 0, 0, 0);
      exp_v = {(k <= 9) ? 6'b000111 : 6'b000000, 4'b0000, (k > 7) ? 3'd7 : 3'(k)};
      @(negedge clk);
      got = obs();
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL saturate cyc%0d: got %b expected %b", k, got, exp_v);
      end
      next_cycle();
    end
  endtask

`ifdef PIPE_CTRL_IO_TIMEOUT_EN
  task automatic test_timeout();
    logic [12:0] exp_t [11];
    logic [12:0] got;
    exp_t = '{{6'b001111, 4'b0000, 3'd0},
              {6'b001111, 4'b1000, 3'd1},
              {6'b001111, 4'b1000, 3'd2},
              {6'b001111, 4'b1000, 3'd3},
              {6'b001111, 4'b1000, 3'd4},
              {6'b000000, 4'b0011, 3'd5},
              {6'b000000, 4'b0001, 3'd5},
              {6'b001111, 4'b0001, 3'd5},
              {6'b001111, 4'b1101, 3'd6},
              {6'b000000, 4'b0111, 3'd7},
              {6'b000000, 4'b0101, 3'd7}};
    do_reset();
    for (int k = 0; k < 11; k++) begin
      set_inputs(0, 0, k <= 5, (k >= 7) && (k <= 9), (k >= 7) && (k <= 9));
      @(negedge clk);
      got = obs();
      vectors++;
      if (got !== exp_t[k]) begin
        miscompares++;
        $display("FAIL timeout cyc%0d: got %b expected %b", k, got, exp_t[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_timeout_ack_wins();
    logic [12:0] exp_t [7];
    logic [12:0] got;
    exp_t = '{{6'b001111, 4'b0000, 3'd0},
              {6'b001111, 4'b1000, 3'd1},
              {6'b001111, 4'b1000, 3'd2},
              {6'b001111, 4'b1000, 3'd3},
              {6'b001111, 4'b1000, 3'd4},
              {6'b000000, 4'b0010, 3'd5},
              {6'b000000, 4'b0000, 3'd5}};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      set_inputs(0, 0, k <= 5, 0, k == 4);
      @(negedge clk);
      got = obs();
      vectors++;
      if (got !== exp_t[k]) begin
        miscompares++;
        $display("FAIL timeout_ack_wins cyc%0d: got %b expected %b", k, got, exp_t[k]);
      end
      next_cycle();
    end
  endtask
`else
  task automatic test_no_timeout();
    logic [12:0] exp_v;
    logic [12:0] got;
    do_reset();
    for (int k = 0; k < 15; k++) begin
      set_inputs(0, 0, k <= 13, 0, (k >= 12) && (k <= 13));
      if (k == 0)
        exp_v = {6'b001111, 4'b0000, 3'd0};
      else if (k <= 12)
        exp_v = {6'b001111, 4'b1000, (k > 7) ? 3'd7 : 3'(k)};
      else if (k == 13)
        exp_v = {6'b000000, 4'b0010, 3'd7};
      else
        exp_v = {6'b000000, 4'b0000, 3'd7};
      @(negedge clk);
      got = obs();
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL no_timeout cyc%0d: got %b expected %b", k, got, exp_v);
      end
      next_cycle();
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    set_inputs(0, 0, 0, 0, 0);
    test_reset();
    test_load_use();
    test_out_ack_delay();
    test_back_to_back();
    test_direction();
    test_combined_and_mid_reset();
    test_saturate();
`ifdef PIPE_CTRL_IO_TIMEOUT_EN
    test_timeout();
    test_timeout_ack_wins();
`else
    test_no_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline stall controller for the 5-stage CPU.
- Merges stall requests from ID (load-use) and EX (multi-cycle ops) into the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Owns the external I/O handshake for IN/OUT instructions: freezes the pipeline while the instruction sits in EX and the device has not yet acknowledged.
- Also counts pipeline stall cycles for performance monitoring.

Parameters:
- CNT_W, 32, width of the stall-cycle counter.
- IO_TIMEOUT_CYCLES, 255, REQ-state cycle limit before forced completion; used only with the optional feature.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset
- stallreq_id  input  1  ID-stage stall request (load-use hazard)
- stallreq_ex  input  1  EX-stage stall request (multi-cycle op)
- ex_in  input  1  EX stage holds an IN instruction
- ex_out  input  1  EX stage holds an OUT instruction
- io_ack  input  1  device acknowledge, level, sampled only in REQ
- stall  output  6  stall vector; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = Stop
- io_req  output  1  registered device request
- io_dir  output  1  registered direction, 1 = OUT, 0 = IN
- io_done  output  1  one-cycle pulse telling EX to latch or finish the I/O transfer
- io_timeout  output  1  sticky timeout flag
- stall_cnt  output  CNT_W  saturating count of cycles with stall[0] = 1

Interface decision (fixed): one clock; reset is synchronous and active-low (clk, rst).

Behaviour:
- Reset (rst = 0 at a clk edge):
  - state = IDLE; io_req = 0; io_dir = 0; io_done = 0; io_timeout = 0; stall_cnt = 0; timeout counter = 0.
  - stall = 6'b000000 while reset is asserted.
- Reset mid-transaction: io_req drops at that edge and no io_done is issued.
- io_pend = ex_in | ex_out.
- FSM states: IDLE, REQ, DONE.
  - IDLE → REQ when io_pend = 1. At the same edge: io_req <= 1; io_dir <= ex_out. If ex_in and ex_out are both 1, ex_out wins.
  - REQ: holds io_req = 1. On the first cycle with io_ack = 1 → DONE, io_req <= 0, io_done <= 1.
  - DONE: io_done = 1 for exactly this cycle; → IDLE unconditionally. DONE never re-triggers on the same instruction.
- Stall vector (combinational from state and requests):
  - stall_io = (IDLE & io_pend) | REQ. DONE does not stall on I/O, so EX/MEM captures the instruction in the DONE cycle.
  - Priority order:
    - stall_io or stallreq_ex → 6'b001111
    - else stallreq_id → 6'b000111
    - else 6'b000000
  - Requests asserted at the same time are OR-combined; the deepest stall pattern wins.
- I/O latency:
  - Instruction enters EX at cycle T; io_req is high from T+1.
  - io_ack first high at cycle A → io_done high at A+1, stall[3] = 0 at A+1.
  - Minimum pipeline freeze with io_ack already high is 2 cycles (T and T+1).
- io_ack while not in REQ is ignored.
- stall_cnt: +1 on every clk edge where stall[0] = 1; saturates at all-ones (no wrap).
- io_dir holds its value after a transaction until the next request.

Optional Feature:
- Macro: PIPE_CTRL_IO_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each REQ cycle without io_ack.
  - When it reaches IO_TIMEOUT_CYCLES: → DONE, io_req <= 0, io_done <= 1, io_timeout <= 1.
  - io_timeout is sticky until reset.
  - If io_ack arrives in the same cycle as the timeout, ack wins and io_timeout is not set.
- Undefined: REQ waits indefinitely; io_timeout is tied to 0; no counter logic is generated.

Test Plan:
- Reset: hold rst = 0 for 3 cycles with all inputs at 1 → stall = 0, io_req = 0, stall_cnt = 0, state IDLE.
- Load-use: stallreq_id = 1 for 1 cycle → stall = 6'b000111 that cycle, then 0; stall_cnt = 1.
- OUT with ack delay: ex_out = 1 at T, io_ack = 1 at T+4 → stall = 6'b001111 for T..T+4; io_req = 1 and io_dir = 1 for T+1..T+4; io_done = 1 only at T+5, stall = 0 at T+5; stall_cnt = 5.
- Back-to-back IN: ex_in = 1 at T, ack tied high → io_req at T+1, io_done at T+2; new ex_in at T+3 → new request at T+4; exactly two io_done pulses.
- Combined requests: stallreq_id = 1 and stallreq_ex = 1 → 6'b001111. rst = 0 during REQ → io_req = 0 next edge, no io_done pulse.
- With PIPE_CTRL_IO_TIMEOUT_EN and IO_TIMEOUT_CYCLES = 4: ex_in with io_ack = 0 → io_done after the 4th REQ cycle, io_timeout = 1 and stays 1; a later transaction with ack leaves io_timeout = 1.
